// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG phase scheduler: FSM states,
// phase encoding, front-end field widths and the captured configuration record.
package ppg_pkg;

  localparam int ADC_W = 8;
  localparam int DC_W  = 7;
  localparam int PGA_W = 4;
  localparam int LED_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RED_SET = 3'd1,
    ST_RED_ACQ = 3'd2,
    ST_IR_SET  = 3'd3,
    ST_IR_ACQ  = 3'd4,
    ST_AMB_SET = 3'd5,
    ST_AMB_ACQ = 3'd6,
    ST_PUBLISH = 3'd7
  } ppg_state_e;

  typedef enum logic [1:0] {
    PH_RED = 2'd0,
    PH_IR  = 2'd1,
    PH_AMB = 2'd2
  } ppg_phase_e;

  typedef struct packed {
    logic [LED_W-1:0] led_drive;
    logic [DC_W-1:0]  red_dc;
    logic [PGA_W-1:0] red_pga;
    logic [DC_W-1:0]  ir_dc;
    logic [PGA_W-1:0] ir_pga;
  } ppg_cfg_t;

  // PUBLISH is grouped with AMB so the analog settings stay on the RED values.
  function automatic ppg_phase_e state_phase(input ppg_state_e s);
    case (s)
      ST_IR_SET, ST_IR_ACQ:               return PH_IR;
      ST_AMB_SET, ST_AMB_ACQ, ST_PUBLISH: return PH_AMB;
      default:                            return PH_RED;
    endcase
  endfunction

  function automatic logic is_set(input ppg_state_e s);
    return (s == ST_RED_SET) || (s == ST_IR_SET) || (s == ST_AMB_SET);
  endfunction

  function automatic logic is_acq(input ppg_state_e s);
    return (s == ST_RED_ACQ) || (s == ST_IR_ACQ) || (s == ST_AMB_ACQ);
  endfunction

  function automatic ppg_state_e seq_next(input ppg_state_e s);
    case (s)
      ST_RED_SET: return ST_RED_ACQ;
      ST_RED_ACQ: return ST_IR_SET;
      ST_IR_SET:  return ST_IR_ACQ;
      ST_IR_ACQ:  return ST_AMB_SET;
      ST_AMB_SET: return ST_AMB_ACQ;
      ST_AMB_ACQ: return ST_PUBLISH;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ppg_boxcar_avg.sv
// Box-car averager shared by all three phases: accumulates one ADC sample per
// enabled cycle and tracks a sticky saturation flag for the current window.
module ppg_boxcar_avg #(
  parameter int ADC_W        = 8,
  parameter int LOG2_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             acc_en,
  input  logic             last,
  input  logic [ADC_W-1:0] adc,
  output logic [ADC_W-1:0] result,
  output logic             sat
);

  localparam int ACC_W = ADC_W + LOG2_SAMPLES;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             sat_q, sat_d;
  logic             adc_sat;

  assign adc_sat = (adc == '0) || (adc == '1);
  assign sum     = acc_q + ACC_W'(adc);

  // The final sample is folded in combinationally so the result is ready on the last cycle.
  assign result = ADC_W'(sum >> LOG2_SAMPLES);
  assign sat    = sat_q | (acc_en & adc_sat);

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (acc_en) begin
      acc_d = last ? '0 : sum;
      sat_d = sat_q | adc_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/ppg_phase_scheduler.sv
// Free-running RED / IR / ambient time-multiplexer for the optical front end.
// Applies per-phase analog settings, averages the ADC and publishes once per frame.
module ppg_phase_scheduler
  import ppg_pkg::*;
#(
  parameter int SETTLE_CYC   = 4,
  parameter int SAMPLE_CYC   = 8,
  parameter int LOG2_SAMPLES = 3
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [LED_W-1:0] cfg_led_drive,
  input  logic [DC_W-1:0]  cfg_red_dc,
  input  logic [PGA_W-1:0] cfg_red_pga,
  input  logic [DC_W-1:0]  cfg_ir_dc,
  input  logic [PGA_W-1:0] cfg_ir_pga,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [LED_W-1:0] LED_DRIVE,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic [ADC_W-1:0] AMB_ADC_Value,
  output logic             sample_valid,
  output logic [2:0]       sat_flags,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYC - 1);

  ppg_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  ppg_cfg_t         shadow_q, shadow_d, act_q, act_d, cfg_in;
  logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [LED_W-1:0] drive_q, drive_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [PGA_W-1:0] pga_q, pga_d;
  logic [ADC_W-1:0] red_hold_q, red_hold_d, ir_hold_q, ir_hold_d;
  logic             red_sat_hold_q, red_sat_hold_d, ir_sat_hold_q, ir_sat_hold_d;
  logic [ADC_W-1:0] red_val_q, red_val_d, ir_val_q, ir_val_d, amb_val_q, amb_val_d;
  logic [2:0]       sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             phase_done, avg_clear, avg_en, avg_last, avg_sat, publish;
  logic [ADC_W-1:0] avg_result;

  assign cfg_in = '{led_drive: cfg_led_drive, red_dc: cfg_red_dc, red_pga: cfg_red_pga,
                    ir_dc: cfg_ir_dc, ir_pga: cfg_ir_pga};

  assign phase_done = (cnt_q == (is_set(state_q) ? SETTLE_LAST : SAMPLE_LAST));
  assign avg_clear  = is_set(state_q);
  assign avg_en     = is_acq(state_q);
  assign avg_last   = avg_en && (cnt_q == SAMPLE_LAST);

  ppg_boxcar_avg #(
    .ADC_W        (ADC_W),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_avg (
    .clk    (CLK),
    .rst    (rst),
    .clear  (avg_clear),
    .acc_en (avg_en),
    .last   (avg_last),
    .adc    (ADC),
    .result (avg_result),
    .sat    (avg_sat)
  );

  // Dropping enable aborts from any active state on the very next edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_RED_SET;
      ST_PUBLISH: state_d = enable ? ST_RED_SET : ST_IDLE;
      default: begin
        if (!enable)         state_d = ST_IDLE;
        else if (phase_done) state_d = seq_next(state_q);
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if ((state_d != state_q) || (state_d == ST_IDLE)) cnt_d = '0;

    shadow_d = cfg_load ? cfg_in : shadow_q;
    // Frame start samples the shadow before any same-cycle cfg_load lands.
    act_d = act_q;
    if ((state_d == ST_RED_SET) && (state_q != ST_RED_SET)) act_d = shadow_q;
  end

  // Front-end outputs are registered from the next state so they align with state_q.
  always_comb begin
    led_red_d = (state_d == ST_RED_SET) || (state_d == ST_RED_ACQ);
    led_ir_d  = (state_d == ST_IR_SET)  || (state_d == ST_IR_ACQ);
    drive_d   = (state_d == ST_IDLE) ? '0 : act_d.led_drive;
    dc_d      = dc_q;
    pga_d     = pga_q;
    if (state_d != ST_IDLE) begin
      if (state_phase(state_d) == PH_IR) begin
        dc_d  = act_d.ir_dc;
        pga_d = act_d.ir_pga;
      end else begin
        dc_d  = act_d.red_dc;
        pga_d = act_d.red_pga;
      end
    end
  end

  // sample_valid: one-cycle strobe, high exactly while the freshly updated
  // RED/IR/AMB values and sat_flags are first presented; no back-pressure.
  always_comb begin
    red_hold_d     = red_hold_q;
    ir_hold_d      = ir_hold_q;
    red_sat_hold_d = red_sat_hold_q;
    ir_sat_hold_d  = ir_sat_hold_q;
    if (avg_last && (state_q == ST_RED_ACQ)) begin
      red_hold_d     = avg_result;
      red_sat_hold_d = avg_sat;
    end
    if (avg_last && (state_q == ST_IR_ACQ)) begin
      ir_hold_d     = avg_result;
      ir_sat_hold_d = avg_sat;
    end

    publish   = (state_d == ST_PUBLISH);
    valid_d   = publish;
    red_val_d = red_val_q;
    ir_val_d  = ir_val_q;
    amb_val_d = amb_val_q;
    sat_d     = sat_q;
    if (publish) begin
      red_val_d = red_hold_q;
      ir_val_d  = ir_hold_q;
      amb_val_d = avg_result;
      sat_d     = {avg_sat, ir_sat_hold_q, red_sat_hold_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      act_q          <= '0;
      led_red_q      <= 1'b0;
      led_ir_q       <= 1'b0;
      drive_q        <= '0;
      dc_q           <= '0;
      pga_q          <= '0;
      red_hold_q     <= '0;
      ir_hold_q      <= '0;
      red_sat_hold_q <= 1'b0;
      ir_sat_hold_q  <= 1'b0;
      red_val_q      <= '0;
      ir_val_q       <= '0;
      amb_val_q      <= '0;
      sat_q          <= '0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      act_q          <= act_d;
      led_red_q      <= led_red_d;
      led_ir_q       <= led_ir_d;
      drive_q        <= drive_d;
      dc_q           <= dc_d;
      pga_q          <= pga_d;
      red_hold_q     <= red_hold_d;
      ir_hold_q      <= ir_hold_d;
      red_sat_hold_q <= red_sat_hold_d;
      ir_sat_hold_q  <= ir_sat_hold_d;
      red_val_q      <= red_val_d;
      ir_val_q       <= ir_val_d;
      amb_val_q      <= amb_val_d;
      sat_q          <= sat_d;
      valid_q        <= valid_d;
    end
  end

  assign LED_RED       = led_red_q;
  assign LED_IR        = led_ir_q;
  assign LED_DRIVE     = drive_q;
  assign DC_Comp       = dc_q;
  assign PGA_Gain      = pga_q;
  assign RED_ADC_Value = red_val_q;
  assign IR_ADC_Value  = ir_val_q;
  assign AMB_ADC_Value = amb_val_q;
  assign sample_valid  = valid_q;
  assign sat_flags     = sat_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ppg_phase_scheduler.sv
// Directed bench for ppg_phase_scheduler: a frame driver checks per-cycle
// front-end outputs, a monitor pops expected published results on sample_valid.
module tb_ppg_phase_scheduler;

  logic       CLK = 1'b0;
  logic       rst, enable, cfg_load;
  logic [3:0] cfg_led_drive, cfg_red_pga, cfg_ir_pga;
  logic [6:0] cfg_red_dc, cfg_ir_dc;
  logic [7:0] ADC;
  logic       LED_RED, LED_IR, sample_valid, busy;
  logic [3:0] LED_DRIVE, PGA_Gain;
  logic [6:0] DC_Comp;
  logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value;
  logic [2:0] sat_flags, dbg_state;

  ppg_phase_scheduler dut (
    .CLK(CLK), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_led_drive(cfg_led_drive), .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
    .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(ADC),
    .LED_RED(LED_RED), .LED_IR(LED_IR), .LED_DRIVE(LED_DRIVE), .DC_Comp(DC_Comp),
    .PGA_Gain(PGA_Gain), .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
    .AMB_ADC_Value(AMB_ADC_Value), .sample_valid(sample_valid), .sat_flags(sat_flags),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam int EXP_W = 59;  // {cycle[31:0], red, ir, amb, sat[2:0]}
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    logic [EXP_W-1:0] e;
    check("led_exclusive", {31'd0, LED_RED & LED_IR}, 32'd0);
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: sample_valid at cycle %0d with nothing expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e[58:27]);
        check("red_value", {24'd0, RED_ADC_Value}, {24'd0, e[26:19]});
        check("ir_value", {24'd0, IR_ADC_Value}, {24'd0, e[18:11]});
        check("amb_value", {24'd0, AMB_ADC_Value}, {24'd0, e[10:3]});
        check("sat_flags", {29'd0, sat_flags}, {29'd0, e[2:0]});
      end
    end
  end

  // ---------------- driver model ----------------
  logic [3:0] sh_drive, sh_red_pga, sh_ir_pga, act_drive, act_red_pga, act_ir_pga;
  logic [6:0] sh_red_dc, sh_ir_dc, act_red_dc, act_ir_dc, pend_red_dc;
  logic       pend = 1'b0;
  logic [7:0] red_pat[8], ir_pat[8], amb_pat[8];

  function automatic logic [7:0] adc_for(input int c);
    if (c >= 4 && c < 12)  return red_pat[c-4];
    if (c >= 16 && c < 24) return ir_pat[c-16];
    if (c >= 28 && c < 36) return amb_pat[c-28];
    return 8'd255;  // settle/publish cycles must be ignored by the averager
  endfunction

  task automatic load_cfg(input logic [3:0] drv, input logic [6:0] rdc, input logic [3:0] rpga,
                          input logic [6:0] idc, input logic [3:0] ipga);
    cfg_led_drive = drv; cfg_red_dc = rdc; cfg_red_pga = rpga; cfg_ir_dc = idc; cfg_ir_pga = ipga;
    cfg_load = 1'b1;
    @(posedge CLK); #1;
    cfg_load = 1'b0;
    sh_drive = drv; sh_red_dc = rdc; sh_red_pga = rpga; sh_ir_dc = idc; sh_ir_pga = ipga;
  endtask

  // Runs one frame from the cycle before frame start; enable must already be 1.
  task automatic run_frame(input int abort_at, input int cfg_at, input logic [6:0] new_red_dc,
                           input logic [7:0] er, input logic [7:0] ei, input logic [7:0] ea,
                           input logic [2:0] es);
    logic [16:0] got, req;
    logic in_ir;
    act_drive = sh_drive; act_red_dc = sh_red_dc; act_red_pga = sh_red_pga;
    act_ir_dc = sh_ir_dc; act_ir_pga = sh_ir_pga;
    if (abort_at < 0) exp_q.push_back({32'(cyc + 37), er, ei, ea, es});
    for (int c = 0; c < 37; c++) begin
      @(posedge CLK); #1;
      if (pend) begin sh_red_dc = pend_red_dc; pend = 1'b0; end
      cfg_load = 1'b0;
      if (c == cfg_at) begin
        cfg_red_dc = new_red_dc; cfg_load = 1'b1; pend = 1'b1; pend_red_dc = new_red_dc;
      end
      ADC = adc_for(c);
      if (c < 36) begin
        in_ir = (c >= 12 && c < 24);
        got = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain};
        req = {c < 12, in_ir, act_drive, in_ir ? act_ir_dc : act_red_dc,
               in_ir ? act_ir_pga : act_red_pga};
        check($sformatf("phase_out_c%0d", c), {15'd0, got}, {15'd0, req});
      end
      if (c == abort_at) begin
        enable = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; ADC = 8'd0;
    cfg_led_drive = '0; cfg_red_dc = '0; cfg_red_pga = '0; cfg_ir_dc = '0; cfg_ir_pga = '0;
    sh_drive = '0; sh_red_dc = '0; sh_red_pga = '0; sh_ir_dc = '0; sh_ir_pga = '0;
    pend_red_dc = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_leds", {30'd0, LED_RED, LED_IR}, 32'd0);
    check("rst_front", {17'd0, LED_DRIVE, DC_Comp, PGA_Gain}, 32'd0);
    check("rst_values", {8'd0, RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value}, 32'd0);
    check("rst_status", {27'd0, sample_valid, sat_flags, busy}, 32'd0);
    rst = 1'b0;
    @(posedge CLK); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    load_cfg(4'd10, 7'd40, 4'd5, 7'd60, 4'd9);

    // Frame 1: flat levels per phase.
    for (int i = 0; i < 8; i++) begin red_pat[i] = 8'd100; ir_pat[i] = 8'd150; amb_pat[i] = 8'd20; end
    enable = 1'b1;
    run_frame(-1, -1, 7'd0, 8'd100, 8'd150, 8'd20, 3'b000);

    // Frame 2: ramp 0..7 truncates to 3 and flags RED saturation; red_dc reload mid IR_ACQ.
    for (int i = 0; i < 8; i++) red_pat[i] = 8'(i);
    run_frame(-1, 18, 7'd77, 8'd3, 8'd150, 8'd20, 3'b001);

    // Frame 3: new red_dc applies; IR full-scale; load coinciding with next frame start.
    for (int i = 0; i < 8; i++) begin red_pat[i] = 8'd200; ir_pat[i] = 8'd255; end
    amb_pat[0] = 8'd1; amb_pat[1] = 8'd2; amb_pat[2] = 8'd3; amb_pat[3] = 8'd4;
    amb_pat[4] = 8'd5; amb_pat[5] = 8'd6; amb_pat[6] = 8'd7; amb_pat[7] = 8'd9;
    run_frame(-1, 36, 7'd11, 8'd200, 8'd255, 8'd4, 3'b010);

    // Frame 4: still uses red_dc=77, aborted during IR_SET.
    run_frame(14, -1, 7'd0, 8'd0, 8'd0, 8'd0, 3'b000);
    @(posedge CLK); #1;
    check("abort_leds", {30'd0, LED_RED, LED_IR}, 32'd0);
    check("abort_busy_drive", {27'd0, busy, LED_DRIVE}, 32'd0);
    check("abort_dc_hold", {21'd0, DC_Comp, PGA_Gain}, {21'd0, 7'd60, 4'd9});
    repeat (5) @(posedge CLK);
    #1;
    check("abort_values_held", {8'd0, RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value},
          {8'd0, 8'd200, 8'd255, 8'd4});
    check("abort_sat_held", {29'd0, sat_flags}, {29'd0, 3'b010});

    // Reset in the middle of RED_ACQ.
    enable = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(posedge CLK); #1;
      ADC = 8'd100;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; enable = 1'b0;
    @(posedge CLK); #1;
    check("mid_rst_front", {15'd0, LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain}, 32'd0);
    check("mid_rst_values", {8'd0, RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value}, 32'd0);
    check("mid_rst_status", {27'd0, sample_valid, sat_flags, busy}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("pending_results", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppg_phase_scheduler.md
Name: ppg_phase_scheduler

Overview:
- Free-running time-multiplexer for the optical front end after calibration. Each frame runs three phases: RED, IR and ambient (both LEDs off).
- In each phase the block applies the stored DC_Comp, PGA_Gain and LED settings, waits a settle window, then box-car averages the ADC.
- At frame end it publishes RED, IR and ambient averages with a one-cycle valid strobe. It sits between the calibration controller (the configuration source) and downstream SpO2 processing.

Parameters:
- SETTLE_CYC, 4, cycles per phase before sampling (1..255)
- SAMPLE_CYC, 8, ADC samples averaged per phase; power of two, 2..256
- LOG2_SAMPLES, 3, log2(SAMPLE_CYC); must match SAMPLE_CYC

Ports:
- CLK  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run frames while high
- cfg_load  in  1  pulse: capture cfg_* into shadow registers
- cfg_led_drive  in  4  LED current code
- cfg_red_dc  in  7  RED DC compensation
- cfg_red_pga  in  4  RED PGA gain
- cfg_ir_dc  in  7  IR DC compensation
- cfg_ir_pga  in  4  IR PGA gain
- ADC  in  8  converter sample, valid every cycle
- LED_RED  out  1  RED LED enable
- LED_IR  out  1  IR LED enable
- LED_DRIVE  out  4  LED current code
- DC_Comp  out  7  DC compensation to analog front end
- PGA_Gain  out  4  PGA gain to analog front end
- RED_ADC_Value  out  8  RED phase average
- IR_ADC_Value  out  8  IR phase average
- AMB_ADC_Value  out  8  ambient phase average
- sample_valid  out  1  one-cycle strobe: all three values updated
- sat_flags  out  3  {amb,ir,red}: an ADC sample of 0 or 255 seen in that window
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - all outputs 0
  - shadow configuration all 0
  - state IDLE
  - counters 0
- Clocking: all state updates on posedge CLK only.
- States: IDLE, RED_SET, RED_ACQ, IR_SET, IR_ACQ, AMB_SET, AMB_ACQ, PUBLISH.
- IDLE:
  - LEDs off; DC_Comp and PGA_Gain hold their last values.
  - When enable=1: go to RED_SET and copy shadow registers into the active frame registers.
- Each *_SET state lasts exactly SETTLE_CYC cycles:
  - outputs are driven for that phase; accumulator cleared; ADC ignored.
- Each *_ACQ state lasts exactly SAMPLE_CYC cycles:
  - every cycle, accumulator += ADC;
  - accumulator width is 8+LOG2_SAMPLES, so it never overflows.
  - On the last ACQ cycle the phase result = (acc + ADC) >> LOG2_SAMPLES, truncating, stored in an internal hold register.
- Phase outputs:
  - RED: LED_RED=1, LED_IR=0, DC_Comp=red_dc, PGA_Gain=red_pga
  - IR: LED_RED=0, LED_IR=1, DC_Comp=ir_dc, PGA_Gain=ir_pga
  - AMB: both LEDs 0, RED settings applied
- LED_DRIVE = active led_drive in all phases except IDLE, where it is 0.
- PUBLISH lasts 1 cycle:
  - RED/IR/AMB_ADC_Value and sat_flags are updated together and sample_valid=1.
  - Outputs then hold until the next PUBLISH.
  - Next state is RED_SET if enable=1, otherwise IDLE.
- Frame period = 3*(SETTLE_CYC+SAMPLE_CYC)+1 cycles (37 with defaults).
- LED exclusivity: LED_RED and LED_IR are never 1 in the same cycle, including on phase transitions.
- cfg_load:
  - Updates the shadow registers only; the active frame is never altered mid-frame.
  - New settings take effect from the next RED_SET entry.
  - cfg_load coinciding with a frame start: the frame uses the previous shadow values.
- enable=0 mid-frame:
  - Abort at the next edge to IDLE, LEDs off.
  - No PUBLISH or sample_valid; published values and sat_flags are retained.
- rst asserted in any state: next edge returns to the reset values listed above.
- A saturation flag is sticky within its ACQ window and cleared when that phase's SET is entered.

Decomposition:
- Package ppg_pkg holds:
  - the state enum;
  - phase encoding {RED, IR, AMB};
  - width constants ADC_W=8, DC_W=7, PGA_W=4.
- One natural sub-module, ppg_boxcar_avg, containing:
  - the accumulator;
  - the saturation detector;
  - the shift result;
  - inputs clear, acc_en, last.
- The FSM, phase counter and output muxing stay in the top level.

Test Plan:
- Basic frame (defaults):
  - Stimulus: cfg red_dc=40, red_pga=5, ir_dc=60, ir_pga=9, led_drive=10; enable=1; ADC=100 during RED_ACQ, 150 during IR_ACQ, 20 during AMB_ACQ.
  - Response: sample_valid on cycle 37 after enable; RED=100, IR=150, AMB=20; sat_flags=0.
- Averaging truncation:
  - Stimulus: RED_ACQ ADC sequence 0,1,2,...,7.
  - Response: RED_ADC_Value=3 (28>>3), sat_flags[0]=1 because 0 was sampled.
- Output sequencing:
  - Check every cycle that LED_RED&LED_IR is never 1.
  - Check DC_Comp=40 and PGA_Gain=5 throughout RED_SET/RED_ACQ/AMB_*, and 60/9 throughout IR_*.
  - Check back-to-back frames have sample_valid spaced exactly 37 cycles.
- Config timing:
  - Stimulus: cfg_load red_dc=77 during IR_ACQ of frame N.
  - Response: DC_Comp stays 40 through frame N; becomes 77 at RED_SET of frame N+1.
- Abort and reset:
  - enable=0 during IR_SET: IDLE next cycle, LEDs 0, no sample_valid, previous values held.
  - rst=1 during RED_ACQ: all outputs 0 next cycle, busy=0.
